// File: rtl/fft8_pkg.sv
// Shared types and constants for the sequenced 8-point FFT: FSM states,
// Q16 twiddles, butterfly schedule ROM and the load-address bit reversal.
package fft8_pkg;

   typedef enum logic [1:0] {LOAD, RUN, OUT} state_t;

   localparam logic [31:0] W0_RE = 32'h0001_0000;
   localparam logic [31:0] W0_IM = 32'h0000_0000;
   localparam logic [31:0] W1_RE = 32'h0000_B504;
   localparam logic [31:0] W1_IM = 32'hFFFF_4AFC;
   localparam logic [31:0] W2_RE = 32'h0000_0000;
   localparam logic [31:0] W2_IM = 32'hFFFF_0000;
   localparam logic [31:0] W3_RE = 32'hFFFF_4AFC;
   localparam logic [31:0] W3_IM = 32'hFFFF_4AFC;

   localparam logic [3:0] LAST_STEP = 4'd11;

   typedef struct packed {
      logic [2:0] p;
      logic [2:0] q;
      logic [1:0] tw;
   } sched_t;

   // Three stages of four butterflies; pairs within a stage are disjoint.
   function automatic sched_t sched_rom(input logic [3:0] step);
      sched_t s;
      case (step)
         4'd0:    s = '{p: 3'd0, q: 3'd1, tw: 2'd0};
         4'd1:    s = '{p: 3'd2, q: 3'd3, tw: 2'd0};
         4'd2:    s = '{p: 3'd4, q: 3'd5, tw: 2'd0};
         4'd3:    s = '{p: 3'd6, q: 3'd7, tw: 2'd0};
         4'd4:    s = '{p: 3'd0, q: 3'd2, tw: 2'd0};
         4'd5:    s = '{p: 3'd1, q: 3'd3, tw: 2'd2};
         4'd6:    s = '{p: 3'd4, q: 3'd6, tw: 2'd0};
         4'd7:    s = '{p: 3'd5, q: 3'd7, tw: 2'd2};
         4'd8:    s = '{p: 3'd0, q: 3'd4, tw: 2'd0};
         4'd9:    s = '{p: 3'd1, q: 3'd5, tw: 2'd1};
         4'd10:   s = '{p: 3'd2, q: 3'd6, tw: 2'd2};
         4'd11:   s = '{p: 3'd3, q: 3'd7, tw: 2'd3};
         default: s = '{p: 3'd0, q: 3'd1, tw: 2'd0};
      endcase
      return s;
   endfunction

   function automatic logic [63:0] twiddle(input logic [1:0] idx);
      logic [63:0] w;
      case (idx)
         2'd0:    w = {W0_RE, W0_IM};
         2'd1:    w = {W1_RE, W1_IM};
         2'd2:    w = {W2_RE, W2_IM};
         default: w = {W3_RE, W3_IM};
      endcase
      return w;
   endfunction

   function automatic logic [2:0] bitrev3(input logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

endpackage

// File: rtl/fft8_bfly.sv
// Combinational radix-2 DIT butterfly: a = x + y*w, b = x - y*w, with
// 48-bit products and truncation to bits [31:16] (floor, no saturation).
module fft8_bfly (
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [63:0] w,
   output logic [31:0] a,
   output logic [31:0] b
);

   logic signed [47:0] xr_s, xi_s, yr_s, yi_s, wr_s, wi_s;
   logic signed [47:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [47:0] sum_ar, sum_ai, sum_br, sum_bi;
   logic unused_bits;

   assign xr_s = {{16{x[31]}}, x[31:16], 16'h0000};
   assign xi_s = {{16{x[15]}}, x[15:0], 16'h0000};
   assign yr_s = {{32{y[31]}}, y[31:16]};
   assign yi_s = {{32{y[15]}}, y[15:0]};
   assign wr_s = {{16{w[63]}}, w[63:32]};
   assign wi_s = {{16{w[31]}}, w[31:0]};

   assign p_rr = yr_s * wr_s;
   assign p_ii = yi_s * wi_s;
   assign p_ri = yr_s * wi_s;
   assign p_ir = yi_s * wr_s;

   assign sum_ar = xr_s + p_rr - p_ii;
   assign sum_ai = xi_s + p_ri + p_ir;
   assign sum_br = xr_s - p_rr + p_ii;
   assign sum_bi = xi_s - p_ri - p_ir;

   assign a = {sum_ar[31:16], sum_ai[31:16]};
   assign b = {sum_br[31:16], sum_bi[31:16]};

   // Bits outside [31:16] are dropped by the Q16 truncation and 16-bit wrap.
   assign unused_bits = ^{sum_ar[47:32], sum_ar[15:0], sum_ai[47:32], sum_ai[15:0],
                          sum_br[47:32], sum_br[15:0], sum_bi[47:32], sum_bi[15:0]};

endmodule

// File: rtl/fft8_seq.sv
// Sequenced 8-point radix-2 DIT FFT: loads a real frame in bit-reversed order,
// runs 12 butterflies on one shared unit, then presents bins with valid/ready.
module fft8_seq
   import fft8_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        data_valid,
   input  logic [15:0] data,
   output logic        data_ready,
   output logic        fft_valid,
   input  logic        fft_ready,
   output logic [31:0] fft_d0,
   output logic [31:0] fft_d1,
   output logic [31:0] fft_d2,
   output logic [31:0] fft_d3,
   output logic [31:0] fft_d4,
   output logic [31:0] fft_d5,
   output logic [31:0] fft_d6,
   output logic [31:0] fft_d7
);

   state_t      state_q, state_d;
   logic [2:0]  count_q;
   logic [3:0]  step_q;
   logic [15:0] buf_re [8];
   logic [15:0] buf_im [8];

   sched_t      sch;
   logic [31:0] bf_x, bf_y, bf_a, bf_b;
   logic [63:0] bf_w;
   logic [31:0] nxt [8];
   logic        run_last;

   always_comb begin
      sch  = sched_rom(step_q);
      bf_x = {buf_re[sch.p], buf_im[sch.p]};
      bf_y = {buf_re[sch.q], buf_im[sch.q]};
      bf_w = twiddle(sch.tw);
   end

   fft8_bfly u_bfly (
      .x (bf_x),
      .y (bf_y),
      .w (bf_w),
      .a (bf_a),
      .b (bf_b)
   );

   // Buffer as it will look after this step; the output load on the final
   // step must include that step's own write-back.
   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         nxt[i] = {buf_re[i], buf_im[i]};
      end
      nxt[sch.p] = bf_a;
      nxt[sch.q] = bf_b;
   end

   assign run_last = (step_q == LAST_STEP);

   always_ff @(posedge clk) begin
      if (rst) state_q <= LOAD;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (data_valid && count_q == 3'd7) state_d = RUN;
         RUN:     if (run_last) state_d = OUT;
         OUT:     if (fft_ready) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      data_ready = (state_q == LOAD);
      fft_valid  = (state_q == OUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         step_q  <= '0;
         fft_d0  <= '0;
         fft_d1  <= '0;
         fft_d2  <= '0;
         fft_d3  <= '0;
         fft_d4  <= '0;
         fft_d5  <= '0;
         fft_d6  <= '0;
         fft_d7  <= '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (data_valid) begin
                  buf_re[bitrev3(count_q)] <= data;
                  buf_im[bitrev3(count_q)] <= '0;
                  count_q <= count_q + 3'd1;
               end
            end
            RUN: begin
               buf_re[sch.p] <= bf_a[31:16];
               buf_im[sch.p] <= bf_a[15:0];
               buf_re[sch.q] <= bf_b[31:16];
               buf_im[sch.q] <= bf_b[15:0];
               step_q <= run_last ? '0 : step_q + 4'd1;
               if (run_last) begin
                  fft_d0 <= nxt[0];
                  fft_d1 <= nxt[1];
                  fft_d2 <= nxt[2];
                  fft_d3 <= nxt[3];
                  fft_d4 <= nxt[4];
                  fft_d5 <= nxt[5];
                  fft_d6 <= nxt[6];
                  fft_d7 <= nxt[7];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fft8_seq.sv
// Self-checking bench for fft8_seq: directed frames with known bins, random
// frames against a stage-by-stage FFT model, backpressure and reset cases.
module tb_fft8_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_valid;
   logic [15:0] data;
   logic        data_ready;
   logic        fft_valid;
   logic        fft_ready;
   logic [31:0] fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
   logic [31:0] d [8];

   int checks = 0;
   int errors = 0;

   logic [15:0] smp [8];
   logic [31:0] exp_d [8];
   logic [31:0] held [8];

   fft8_seq dut (
      .clk        (clk),
      .rst        (rst),
      .data_valid (data_valid),
      .data       (data),
      .data_ready (data_ready),
      .fft_valid  (fft_valid),
      .fft_ready  (fft_ready),
      .fft_d0     (fft_d0),
      .fft_d1     (fft_d1),
      .fft_d2     (fft_d2),
      .fft_d3     (fft_d3),
      .fft_d4     (fft_d4),
      .fft_d5     (fft_d5),
      .fft_d6     (fft_d6),
      .fft_d7     (fft_d7)
   );

   assign d[0] = fft_d0;
   assign d[1] = fft_d1;
   assign d[2] = fft_d2;
   assign d[3] = fft_d3;
   assign d[4] = fft_d4;
   assign d[5] = fft_d5;
   assign d[6] = fft_d6;
   assign d[7] = fft_d7;

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic longint wrap16(input longint v);
      logic [15:0] t;
      t = v[15:0];
      return longint'($signed(t));
   endfunction

   function automatic int rev3(input int n);
      logic [2:0] b;
      b = n[2:0];
      return int'({b[0], b[1], b[2]});
   endfunction

   // Textbook in-place DIT: span doubles per stage, twiddle W8^(j*8/(2*span)).
   task automatic compute_model();
      longint re [8];
      longint im [8];
      longint twr [4];
      longint twi [4];
      twr = '{65536, 46340, 0, -46340};
      twi = '{0, -46340, -65536, -46340};
      for (int n = 0; n < 8; n++) begin
         re[rev3(n)] = longint'($signed(smp[n]));
         im[rev3(n)] = 0;
      end
      for (int s = 0; s < 3; s++) begin
         int span;
         span = 1 << s;
         for (int g = 0; g < 8; g += 2 * span) begin
            for (int j = 0; j < span; j++) begin
               int p, q, e;
               longint tr, ti, xr, xi;
               p  = g + j;
               q  = p + span;
               e  = j * (4 >> s);
               tr = re[q] * twr[e] - im[q] * twi[e];
               ti = re[q] * twi[e] + im[q] * twr[e];
               xr = re[p] * 65536;
               xi = im[p] * 65536;
               re[p] = wrap16((xr + tr) >>> 16);
               im[p] = wrap16((xi + ti) >>> 16);
               re[q] = wrap16((xr - tr) >>> 16);
               im[q] = wrap16((xi - ti) >>> 16);
            end
         end
      end
      for (int k = 0; k < 8; k++) begin
         logic [15:0] r16, i16;
         r16 = re[k][15:0];
         i16 = im[k][15:0];
         exp_d[k] = {r16, i16};
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic send_frame(input int gap_max);
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            data_valid = 1'b0;
            data       = 16'($urandom);
            @(negedge clk);
         end
         data_valid = 1'b1;
         data       = smp[i];
         @(negedge clk);
      end
      data_valid = 1'b0;
   endtask

   // Count negedges from the one right after sample 7 until fft_valid.
   task automatic wait_valid(output int n);
      n = 0;
      while (fft_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic handshake();
      fft_ready = 1'b1;
      @(negedge clk);
      fft_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; data_valid = 1'b0; data = '0; fft_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_data_ready got %b exp 1", data_ready); end
      checks++;
      if (fft_valid !== 1'b0) begin errors++; $display("FAIL reset_fft_valid got %b exp 0", fft_valid); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (d[k] !== 32'h0) begin errors++; $display("FAIL reset_d%0d got %h exp 00000000", k, d[k]); end
      end
   endtask

   task automatic test_impulse();
      int n;
      foreach (smp[i]) smp[i] = '0;
      smp[0] = 16'd1;
      send_frame(0);
      wait_valid(n);
      checks++;
      if (n !== 12) begin errors++; $display("FAIL impulse_latency got %0d exp 12", n); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (d[k] !== 32'h0001_0000) begin errors++; $display("FAIL impulse_d%0d got %h exp 00010000", k, d[k]); end
      end
      handshake();
      checks++;
      if (data_ready !== 1'b1 || fft_valid !== 1'b0) begin
         errors++; $display("FAIL impulse_return got ready=%b valid=%b exp ready=1 valid=0", data_ready, fft_valid);
      end
   endtask

   task automatic test_dc();
      int n;
      foreach (smp[i]) smp[i] = 16'd100;
      send_frame(1);
      wait_valid(n);
      checks++;
      if (d[0] !== 32'h0320_0000) begin errors++; $display("FAIL dc_d0 got %h exp 03200000", d[0]); end
      for (int k = 1; k < 8; k++) begin
         checks++;
         if (d[k] !== 32'h0) begin errors++; $display("FAIL dc_d%0d got %h exp 00000000", k, d[k]); end
      end
      handshake();
   endtask

   task automatic test_alternating();
      int n;
      foreach (smp[i]) smp[i] = (i % 2 == 0) ? 16'h0001 : 16'hFFFF;
      send_frame(0);
      wait_valid(n);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (d[k] !== ((k == 4) ? 32'h0008_0000 : 32'h0)) begin
            errors++; $display("FAIL alt_d%0d got %h exp %h", k, d[k], (k == 4) ? 32'h0008_0000 : 32'h0);
         end
      end
      handshake();
   endtask

   task automatic test_impulse1();
      int n;
      logic [31:0] want [8];
      want = '{32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0001, 32'h0000_0000};
      foreach (smp[i]) smp[i] = '0;
      smp[1] = 16'd1;
      send_frame(0);
      wait_valid(n);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (d[k] !== want[k]) begin errors++; $display("FAIL imp1_d%0d got %h exp %h", k, d[k], want[k]); end
      end
      // Leave outputs populated so the mid-run reset test sees them clear.
      handshake();
   endtask

   task automatic test_random();
      int n;
      for (int f = 0; f < 6; f++) begin
         foreach (smp[i]) smp[i] = (f < 3) ? 16'($urandom_range(4095, 0) - 2048) : 16'($urandom);
         compute_model();
         send_frame(2);
         wait_valid(n);
         checks++;
         if (n !== 12) begin errors++; $display("FAIL rand%0d_latency got %0d exp 12", f, n); end
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (d[k] !== exp_d[k]) begin errors++; $display("FAIL rand%0d_d%0d got %h exp %h", f, k, d[k], exp_d[k]); end
         end
         repeat ($urandom_range(3, 0)) @(negedge clk);
         checks++;
         if (fft_valid !== 1'b1) begin errors++; $display("FAIL rand%0d_hold got %b exp 1", f, fft_valid); end
         handshake();
      end
   endtask

   task automatic test_hold_valid();
      int n;
      foreach (smp[i]) smp[i] = 16'($urandom);
      compute_model();
      for (int i = 0; i < 8; i++) begin
         data_valid = 1'b1; data = smp[i];
         @(negedge clk);
      end
      data = 16'h7FFF;
      @(negedge clk);
      data_valid = 1'b0;
      wait_valid(n);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (d[k] !== exp_d[k]) begin errors++; $display("FAIL holdv_d%0d got %h exp %h", k, d[k], exp_d[k]); end
      end
      handshake();
   endtask

   task automatic test_backpressure();
      int n;
      foreach (smp[i]) smp[i] = 16'($urandom);
      compute_model();
      send_frame(0);
      wait_valid(n);
      for (int c = 0; c < 5; c++) begin
         data_valid = 1'b1; data = 16'($urandom);
         @(negedge clk);
         checks++;
         if (data_ready !== 1'b0 || fft_valid !== 1'b1) begin
            errors++; $display("FAIL bp_flags%0d got ready=%b valid=%b exp ready=0 valid=1", c, data_ready, fft_valid);
         end
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (d[k] !== exp_d[k]) begin errors++; $display("FAIL bp_hold%0d_d%0d got %h exp %h", c, k, d[k], exp_d[k]); end
         end
      end
      handshake();
      data_valid = 1'b0;
      foreach (smp[i]) smp[i] = 16'($urandom);
      compute_model();
      send_frame(0);
      wait_valid(n);
      checks++;
      if (n !== 12) begin errors++; $display("FAIL bp_next_latency got %0d exp 12", n); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (d[k] !== exp_d[k]) begin errors++; $display("FAIL bp_next_d%0d got %h exp %h", k, d[k], exp_d[k]); end
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      int n;
      fft_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         foreach (smp[i]) smp[i] = 16'($urandom);
         compute_model();
         send_frame(0);
         wait_valid(n);
         checks++;
         if (n !== 12) begin errors++; $display("FAIL b2b%0d_latency got %0d exp 12", f, n); end
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (d[k] !== exp_d[k]) begin errors++; $display("FAIL b2b%0d_d%0d got %h exp %h", f, k, d[k], exp_d[k]); end
         end
         @(negedge clk);
         checks++;
         if (fft_valid !== 1'b0 || data_ready !== 1'b1) begin
            errors++; $display("FAIL b2b%0d_pulse got valid=%b ready=%b exp valid=0 ready=1", f, fft_valid, data_ready);
         end
      end
      fft_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int n;
      foreach (smp[i]) smp[i] = 16'($urandom);
      send_frame(0);
      // Six more edges complete steps 0..5, so the next edge would run step 6.
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (fft_valid !== 1'b0 || data_ready !== 1'b1) begin
         errors++; $display("FAIL rstrun_flags got valid=%b ready=%b exp valid=0 ready=1", fft_valid, data_ready);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (d[k] !== 32'h0) begin errors++; $display("FAIL rstrun_d%0d got %h exp 00000000", k, d[k]); end
      end
      foreach (smp[i]) smp[i] = 16'd100;
      send_frame(0);
      wait_valid(n);
      checks++;
      if (n !== 12) begin errors++; $display("FAIL rstrun_latency got %0d exp 12", n); end
      checks++;
      if (d[0] !== 32'h0320_0000) begin errors++; $display("FAIL rstrun_dc_d0 got %h exp 03200000", d[0]); end
      handshake();
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_dc();
      test_alternating();
      test_impulse1();
      test_reset_mid_run();
      test_random();
      test_hold_valid();
      test_backpressure();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft8_seq.md
# fft8_seq

Sequenced 8-point radix-2 DIT FFT engine that time-shares a single butterfly unit across all 12 butterflies of the transform. It accepts a real 16-bit sample stream, buffers one frame, runs 3 stages × 4 butterflies at one butterfly per clock, and presents the 8 complex bins in parallel with a valid/ready handshake. It is the area-reduced replacement for the fully unrolled 8-point FFT in the same signal path, with the same sample and bin formats.

## Interface
- No parameters. N=8 and the Q16 twiddle table are fixed.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- data_valid  in  1  sample strobe
- data  in  16  signed real sample
- data_ready  out  1  high when a sample can be accepted (LOAD state)
- fft_valid  out  1  bins valid (OUT state)
- fft_ready  in  1  downstream accepts bins
- fft_d0 … fft_d7  out  32 each  bin k = {re[15:0], im[15:0]}, signed two's complement

## Operation
- One clock domain and a synchronous active-high reset, as already decided. Ports are named clk and rst.
- Buffer: 8 complex slots of 16+16 bits.
  - Sample n is written to slot bitrev3(n) with im=0.
  - Slot order after load: x0,x4,x2,x6,x1,x5,x3,x7.
- FSM states:
  - LOAD: data_ready=1. Each cycle with data_valid=1 writes one sample and increments a 3-bit count. Accepting sample 7 moves to RUN and clears the count.
  - RUN: 12 cycles, step 0..11. Each step reads two slots, applies the butterfly, and writes both results back in the same cycle. After step 11, fft_d0..7 are loaded from slots 0..7 and the FSM moves to OUT.
  - OUT: fft_valid=1 and fft_d* are held stable. When fft_valid&fft_ready, the FSM returns to LOAD.
- Samples presented while data_ready=0 are dropped. No error flag is raised.
- Schedule, written as (p,q,twiddle):
  - Stage 0: (0,1,W0) (2,3,W0) (4,5,W0) (6,7,W0)
  - Stage 1: (0,2,W0) (1,3,W2) (4,6,W0) (5,7,W2)
  - Stage 2: (0,4,W0) (1,5,W1) (2,6,W2) (3,7,W3)
- Twiddles, as 32-bit signed Q16 (re, im):
  - W0 = (0x00010000, 0x00000000)
  - W1 = (0x0000B504, 0xFFFF4AFC)
  - W2 = (0x00000000, 0xFFFF0000)
  - W3 = (0xFFFF4AFC, 0xFFFF4AFC)
- Butterfly arithmetic, with x = slot p and y = slot q:
  - Products are 48-bit: yr·wr, yi·wi, yr·wi, yi·wr.
  - ar = bits[31:16] of (xr<<16)+yr·wr−yi·wi
  - ai = bits[31:16] of (xi<<16)+yr·wi+yi·wr
  - br = bits[31:16] of (xr<<16)−yr·wr+yi·wi
  - bi = bits[31:16] of (xi<<16)−yr·wi−yi·wr
  - Results truncate (floor). There is no saturation; 16-bit wrap is accepted.
  - a is written to slot p, b to slot q.

## Timing
- Reset values:
  - State LOAD, count 0, step 0.
  - data_ready=1 in the first cycle after reset.
  - fft_valid=0.
  - fft_d0..7=0.
  - Buffer contents are don't-care.
- Latency: if sample 7 is accepted at edge T, RUN occupies edges T+1..T+12, and fft_valid rises after edge T+12 (visible in cycle T+13).
- With fft_ready tied high, fft_valid is a 1-cycle pulse and data_ready returns one cycle later. Frame period is at least 8+12+1 = 21 cycles.
- Backpressure: in OUT with fft_ready=0, fft_valid and fft_d* hold indefinitely and data_ready stays 0.
- data_ready and fft_valid are registered state decodes and are never high together.
- Reset at any point (mid-LOAD, mid-RUN, in OUT) returns to the reset values on the next edge. A partial frame is discarded.
- data_valid held high across the LOAD→RUN transition: the sample in the first RUN cycle is dropped.

## Structure
- Package fft8_pkg holds:
  - the state enum {LOAD, RUN, OUT}
  - twiddle constants W0..W3 (re/im, 32-bit)
  - the 12-entry schedule ROM (p, q, twiddle index)
  - a bitrev3 function
- Sub-module fft8_bfly: combinational butterfly with exactly the arithmetic above (inputs x, y, w; outputs a, b). fft8_seq instantiates one.
- fft8_seq contains the FSM, counters, buffer, and output registers.

## Test plan
- Impulse x0=1, others 0 → all fft_d0..7 = 0x00010000. fft_valid appears 13 cycles after sample 7 is accepted.
- DC: all eight samples = 100 → fft_d0 = 0x03200000; d1..d7 = 0.
- Alternating 1,−1,1,−1,… → fft_d4 = 0x00080000; all other bins 0.
- Impulse x1=1 (truncation check) → d0=0x00010000, d1=0x0000FFFF, d2=0x0000FFFF, d3=0xFFFFFFFF, d4=0xFFFF0000, d5=0xFFFF0000, d6=0x00000001, d7=0x00000000.
- Backpressure: hold fft_ready=0 for 5 cycles in OUT while driving data_valid=1 →
  - outputs stay stable
  - data_ready stays 0
  - the driven samples are dropped
  - the next frame after the handshake is computed correctly.
- Reset at RUN step 6 → next cycle fft_valid=0, fft_d*=0, data_ready=1. A fresh DC frame then yields d0=0x03200000.
